// File: rtl/buffer_sched_pkg.sv
// Shared types and helpers for the ping-pong buffer scheduler.
// Holds the fill/process FSM state encodings, the half indices and the
// helper that maps a half index to its base address in the shared buffer.
package buffer_sched_pkg;

    typedef enum logic [1:0] {
        F_BOOT = 2'd0,
        F_IDLE = 2'd1,
        F_REQ  = 2'd2,
        F_FILL = 2'd3
    } fill_state_t;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_RUN  = 1'b1
    } proc_state_t;

    localparam logic HALF_A = 1'b0;
    localparam logic HALF_B = 1'b1;

    localparam int STAT_W = 16;

    // Base address of a half: half A starts at 0, half B at the midpoint.
    // The caller casts the result down to its own address width.
    function automatic logic [31:0] half_base(input logic half, input int unsigned addr_w);
        return {31'd0, half} << (addr_w - 1);
    endfunction

endpackage

// File: rtl/buffer_sched_ack_timer.sv
// Acknowledge watchdog for the fill request handshake.
// start opens a new wait window (retry count kept), clear stops the window
// and forgets all retries. expire pulses when a window runs ACK_TIMEOUT
// cycles without being cleared; give_up is expire on the final allowed retry.
module buffer_sched_ack_timer #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int RETRY_MAX   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expire,
    output logic give_up
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(RETRY_MAX + 1);

    logic [CNT_W-1:0] count_reg;
    logic [RTY_W-1:0] retry_reg;
    logic             running_reg;

    assign expire  = running_reg && (count_reg == CNT_W'(ACK_TIMEOUT - 1));
    assign give_up = expire && (retry_reg == RTY_W'(RETRY_MAX - 1));

    // Window counter and retry tally; clear beats start beats expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            retry_reg   <= '0;
            running_reg <= 1'b0;
        end else if (clear) begin
            count_reg   <= '0;
            retry_reg   <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            count_reg   <= '0;
            running_reg <= 1'b1;
        end else if (expire) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
            if (retry_reg != RTY_W'(RETRY_MAX))
                retry_reg <= retry_reg + 1'b1;
        end else if (running_reg) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/buffer_pingpong_scheduler.sv
// Ping-pong sequencer for the shared dual-port buffer: one half is filled
// by the fill engine while the other is read by the process engine.
// Optional build macro BUF_SCHED_STATS_EN adds the starve_cnt and
// overrun_stall_cnt saturating statistics outputs.
module buffer_pingpong_scheduler
    import buffer_sched_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 1024,
    parameter int RETRY_MAX   = 3
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              filler_booting,
    output logic              fill_req,
    output logic              fill_half,
    output logic [ADDR_W-1:0] fill_base,
    input  logic              fill_ack,
    input  logic              fill_done,
    output logic              proc_start,
    output logic              proc_half,
    output logic [ADDR_W-1:0] proc_base,
    input  logic              proc_done,
    output logic [1:0]        half_full,
    output logic              err_protocol,
    output logic              err_timeout
`ifdef BUF_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0] starve_cnt,
    output logic [STAT_W-1:0] overrun_stall_cnt
`endif
);

    fill_state_t       fill_state_reg;
    proc_state_t       proc_state_reg;
    logic              next_fill_reg;
    logic              next_proc_reg;
    logic              req_gap_reg;
    logic              fill_req_reg;
    logic              fill_half_reg;
    logic [ADDR_W-1:0] fill_base_reg;
    logic              proc_start_reg;
    logic              proc_half_reg;
    logic [ADDR_W-1:0] proc_base_reg;
    logic [1:0]        half_full_reg;
    logic              err_protocol_reg;
    logic              err_timeout_reg;

    logic       fill_slot_free;
    logic       fill_set;
    logic       proc_clr;
    logic [1:0] set_vec;
    logic [1:0] clr_vec;
    logic       proto_err;
    logic       timer_start;
    logic       timer_clear;
    logic       timer_expire;
    logic       timer_give_up;

    // A half may be requested only if it is empty and not being read.
    assign fill_slot_free = !half_full_reg[next_fill_reg] &&
                            !(proc_state_reg == P_RUN && proc_half_reg == next_fill_reg);

    assign fill_set = (fill_state_reg == F_FILL) && fill_done && !filler_booting;
    assign proc_clr = (proc_state_reg == P_RUN) && proc_done;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign set_vec[gi] = fill_set && (fill_half_reg == 1'(gi));
            assign clr_vec[gi] = proc_clr && (proc_half_reg == 1'(gi));
        end
    endgenerate

    assign proto_err = (fill_ack  && fill_state_reg != F_REQ)  ||
                       (fill_done && fill_state_reg != F_FILL) ||
                       (proc_done && proc_state_reg != P_RUN)  ||
                       (|(set_vec & clr_vec));

    // A wait window opens on the first request and again after each one-cycle gap.
    assign timer_start = !filler_booting &&
                         (((fill_state_reg == F_IDLE) && fill_slot_free) ||
                          ((fill_state_reg == F_REQ) && req_gap_reg && !fill_ack));
    assign timer_clear = (fill_state_reg == F_REQ) &&
                         (filler_booting || fill_ack || timer_give_up);

    buffer_sched_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .RETRY_MAX   (RETRY_MAX)
    ) u_ack_timer (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .start   (timer_start),
        .clear   (timer_clear),
        .expire  (timer_expire),
        .give_up (timer_give_up)
    );

    // Fill FSM: boot wait, request handshake with retries, fill completion.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fill_state_reg  <= F_BOOT;
            next_fill_reg   <= HALF_A;
            req_gap_reg     <= 1'b0;
            fill_req_reg    <= 1'b0;
            fill_half_reg   <= HALF_A;
            fill_base_reg   <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            case (fill_state_reg)
                F_BOOT: begin
                    fill_req_reg <= 1'b0;
                    req_gap_reg  <= 1'b0;
                    if (!filler_booting)
                        fill_state_reg <= F_IDLE;
                end
                F_IDLE: begin
                    if (filler_booting) begin
                        fill_state_reg <= F_BOOT;
                    end else if (fill_slot_free) begin
                        fill_state_reg <= F_REQ;
                        fill_req_reg   <= 1'b1;
                        fill_half_reg  <= next_fill_reg;
                        fill_base_reg  <= ADDR_W'(half_base(next_fill_reg, ADDR_W));
                    end
                end
                F_REQ: begin
                    if (filler_booting) begin
                        fill_state_reg <= F_BOOT;
                        fill_req_reg   <= 1'b0;
                        req_gap_reg    <= 1'b0;
                    end else if (fill_ack) begin
                        fill_state_reg <= F_FILL;
                        fill_req_reg   <= 1'b0;
                        req_gap_reg    <= 1'b0;
                    end else if (req_gap_reg) begin
                        fill_req_reg <= 1'b1;
                        req_gap_reg  <= 1'b0;
                    end else if (timer_give_up) begin
                        fill_state_reg  <= F_BOOT;
                        fill_req_reg    <= 1'b0;
                        err_timeout_reg <= 1'b1;
                    end else if (timer_expire) begin
                        fill_req_reg <= 1'b0;
                        req_gap_reg  <= 1'b1;
                    end
                end
                F_FILL: begin
                    if (filler_booting) begin
                        fill_state_reg <= F_BOOT;
                    end else if (fill_done) begin
                        fill_state_reg <= F_IDLE;
                        next_fill_reg  <= ~next_fill_reg;
                    end
                end
                default: fill_state_reg <= F_BOOT;
            endcase
        end
    end

    // Process FSM: start reading the next full half, release it on proc_done.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            proc_state_reg <= P_IDLE;
            next_proc_reg  <= HALF_A;
            proc_start_reg <= 1'b0;
            proc_half_reg  <= HALF_A;
            proc_base_reg  <= '0;
        end else begin
            proc_start_reg <= 1'b0;
            case (proc_state_reg)
                P_IDLE: begin
                    if (half_full_reg[next_proc_reg]) begin
                        proc_state_reg <= P_RUN;
                        proc_start_reg <= 1'b1;
                        proc_half_reg  <= next_proc_reg;
                        proc_base_reg  <= ADDR_W'(half_base(next_proc_reg, ADDR_W));
                    end
                end
                P_RUN: begin
                    if (proc_done) begin
                        proc_state_reg <= P_IDLE;
                        next_proc_reg  <= ~next_proc_reg;
                    end
                end
                default: proc_state_reg <= P_IDLE;
            endcase
        end
    end

    // Occupancy flags (clear wins on collision) and sticky protocol error.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            half_full_reg    <= 2'b00;
            err_protocol_reg <= 1'b0;
        end else begin
            half_full_reg <= (half_full_reg | set_vec) & ~clr_vec;
            if (proto_err)
                err_protocol_reg <= 1'b1;
        end
    end

`ifdef BUF_SCHED_STATS_EN
    logic              first_fill_reg;
    logic [STAT_W-1:0] starve_cnt_reg;
    logic [STAT_W-1:0] overrun_cnt_reg;

    // Saturating starvation / overrun-stall counters, cleared only by reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            first_fill_reg  <= 1'b0;
            starve_cnt_reg  <= '0;
            overrun_cnt_reg <= '0;
        end else begin
            if (fill_set)
                first_fill_reg <= 1'b1;
            if (first_fill_reg && proc_state_reg == P_IDLE && half_full_reg == 2'b00 &&
                starve_cnt_reg != {STAT_W{1'b1}})
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            if (fill_state_reg == F_IDLE && half_full_reg == 2'b11 &&
                overrun_cnt_reg != {STAT_W{1'b1}})
                overrun_cnt_reg <= overrun_cnt_reg + 1'b1;
        end
    end

    assign starve_cnt        = starve_cnt_reg;
    assign overrun_stall_cnt = overrun_cnt_reg;
`endif

    assign fill_req     = fill_req_reg;
    assign fill_half    = fill_half_reg;
    assign fill_base    = fill_base_reg;
    assign proc_start   = proc_start_reg;
    assign proc_half    = proc_half_reg;
    assign proc_base    = proc_base_reg;
    assign half_full    = half_full_reg;
    assign err_protocol = err_protocol_reg;
    assign err_timeout  = err_timeout_reg;

endmodule
